// File: rtl/serial_add_pkg.sv
// Shared definitions for the digit-serial adder: nibble width, default digit count, FSM states.
package serial_add_pkg;
    localparam int NIBBLE_W        = 4;
    localparam int DEFAULT_NIBBLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice, zero latency, no flow control.
// Optional c3 (carry into the top bit) exists only when ADD_OVF_EN is defined.
module nibble_add_slice
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
`ifdef ADD_OVF_EN
    ,
    output logic                c3
`endif
);

    logic [NIBBLE_W:0] full;

    always_comb begin
        full = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};
        s    = full[NIBBLE_W-1:0];
        co   = full[NIBBLE_W];
    end

`ifdef ADD_OVF_EN
    // Carry into the top bit is recovered from its sum bit and operand bits.
    assign c3 = x[NIBBLE_W-1] ^ y[NIBBLE_W-1] ^ s[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_add16.sv
// Digit-serial W-bit adder: result valid NIBBLES cycles after accept, held in DONE until out_ready.
// ADD_OVF_EN adds the registered signed-overflow output ovf.
module nibble_serial_add16
    import serial_add_pkg::*;
#(
    parameter  int NIBBLES = DEFAULT_NIBBLES,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [W-1:0]          op_a;
    logic [W-1:0]          op_b;
    logic                  carry_reg;
    logic [NIBBLE_W-1:0]   sl_x;
    logic [NIBBLE_W-1:0]   sl_y;
    logic [NIBBLE_W-1:0]   sl_s;
    logic                  sl_co;
`ifdef ADD_OVF_EN
    logic                  sl_c3;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the operand digit addressed by the nibble counter.
    always_comb begin
        sl_x = '0;
        sl_y = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                sl_x = op_a[i*NIBBLE_W +: NIBBLE_W];
                sl_y = op_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_add_slice u_slice (
        .x  (sl_x),
        .y  (sl_y),
        .ci (carry_reg),
        .s  (sl_s),
        .co (sl_co)
`ifdef ADD_OVF_EN
        ,
        .c3 (sl_c3)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a      <= a;
                        op_b      <= b;
                        carry_reg <= cin;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CW'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= sl_s;
                    end
                    carry_reg <= sl_co;
                    if (cnt == LAST) begin
                        cout  <= sl_co;
`ifdef ADD_OVF_EN
                        ovf   <= sl_c3 ^ sl_co;
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
